serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that time-multiplexes a single `full_adder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. It latches the operands on a start request, steps the cell through WIDTH cycles while holding the carry in a flip-flop, and then presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the shared 1-bit adder cell, trading latency for area.

---
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder cell stepped LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] last_bit = CW'(WIDTH - 1);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_run  = 2'd1;
   localparam logic [1:0] st_done = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
   logic             carry_reg, cout_reg;
   logic [CW-1:0]    cnt_reg;
   logic             accept;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_s, fa_co;

   full_adder u_fa (
      .a   (a_sh_reg[0]),
      .b   (b_sh_reg[0]),
      .cin (carry_reg),
      .s   (fa_s),
      .co  (fa_co)
   );

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and inject a carry of one.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign accept = start && (state_reg == st_idle || state_reg == st_done);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         st_idle: if (start) state_next = st_run;
         st_run:  if (cnt_reg == last_bit) state_next = st_done;
         st_done: state_next = start ? st_run : st_idle;
         default: state_next = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= st_idle;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
         end else if (state_reg == st_run) begin
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
            a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
            carry_reg <= fa_co;
            cnt_reg   <= cnt_reg + CW'(1);
            if (cnt_reg == last_bit) cout_reg <= fa_co;
         end
      end
   end

   assign busy = (state_reg == st_run);
   assign done = (state_reg == st_done);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); inputs driven and
// outputs sampled on the falling edge, one cycle per falling edge.

module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, cin, sub;
   logic [7:0] a, b;
   logic       busy, done, cout;
   logic [7:0] sum;
   int         tests = 0;
   int         fails = 0;
   int         dcount;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on the falling edge of cycle 0; returns on the falling edge of the done cycle.
   task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input logic ts, input logic [7:0] es, input logic ec, input string tag);
      a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'h5A; b = 8'hC3; cin = ~tc; sub = ~ts;
      for (int i = 1; i <= 8; i++) begin
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_nodone"}, {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic add, then results held in IDLE
      op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, "add");
      @(negedge clk);
      check("add_pulse", {31'd0, done}, 32'd0);
      check("add_idle", {31'd0, busy}, 32'd0);
      check("add_hold", {24'd0, sum}, 32'h7F);
      @(negedge clk);
      @(negedge clk);
      check("add_hold2", {24'd0, sum}, 32'h7F);

      op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "carry1");
      @(negedge clk);
      op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "carry2");
      @(negedge clk);

      // start and a change during RUN are ignored
      dcount = 0;
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (done) dcount++;
         if (c == 9) begin
            check("ign_done", {31'd0, done}, 32'd1);
            check("ign_sum", {24'd0, sum}, 32'h30);
            check("ign_cout", {31'd0, cout}, 32'd0);
         end
         if (c == 3) begin start = 1'b1; a = 8'hAA; end
         if (c == 4) start = 1'b0;
         @(negedge clk);
      end
      check("ign_once", dcount, 32'd1);

      // Reset in cycle 4 of an operation
      a = 8'h55; b = 8'h0F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_done", {31'd0, done}, 32'd0);
      check("mid_sum", {24'd0, sum}, 32'd0);
      check("mid_cout", {31'd0, cout}, 32'd0);

      // Back-to-back: second start issued in the DONE cycle
      op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, "b2b1");
      op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, "b2b2");
      @(negedge clk);

      // Reset and start together: reset wins
      rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rs_busy", {31'd0, busy}, 32'd0);
      check("rs_sum", {24'd0, sum}, 32'd0);
      @(negedge clk);
      check("rs_busy2", {31'd0, busy}, 32'd0);
      check("rs_done2", {31'd0, done}, 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
      op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub1");
      @(negedge clk);
      op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, "sub2");
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
